// File: rtl/cpu_pkg.sv
// Shared types and widths for the fetch path and its branch-target lookup table.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

  localparam int LUT_PTR_W  = 5;
  localparam int LUT_DATA_W = 8;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: sequential, PC-relative or absolute target.
module pc_next
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0]              pc,
  input  logic signed [LUT_DATA_W-1:0] lut_offset,
  input  logic                         abs_jump,
  input  logic                         taken,
  output logic [PC_W-1:0]              next_pc,
  output logic                         bad_jump
);

  logic signed [PC_W-1:0] off_sext;
  logic [PC_W-1:0]        off_zext;

  // Relative offsets sign-extend; absolute targets are an unsigned table entry.
  assign off_sext = PC_W'(lut_offset);
  assign off_zext = PC_W'($unsigned(lut_offset));

  always_comb begin
    next_pc  = pc + 1'b1;
    bad_jump = 1'b0;
    if (taken) begin
      if (abs_jump) begin
        next_pc = off_zext;
      end else begin
        next_pc  = pc + $unsigned(off_sext);
        // An unpopulated table entry reads as zero and would spin forever.
        bad_jump = (lut_offset == '0);
      end
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer: run/halt/done control, jump application and retired-instruction count.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Stall,
  input  logic                  Halt,
  input  logic                  Jump,
  input  logic                  JumpCond,
  input  logic                  AbsJump,
  input  logic [LUT_PTR_W-1:0]  TargetPtr,
  output logic [LUT_PTR_W-1:0]  LutPtr,
  input  logic [LUT_DATA_W-1:0] LutOffset,
  output logic [PC_W-1:0]       PC,
  output logic                  Busy,
  output logic                  Done,
  output logic                  BadJump,
  output logic [CNT_W-1:0]      InstCount
);

  pc_state_t        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;

  logic [PC_W-1:0]  seq_pc;
  logic             bad_jump;
  logic             taken;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign LutPtr = TargetPtr;
  assign taken  = Jump & JumpCond;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc         (pc_q),
    .lut_offset (signed'(LutOffset)),
    .abs_jump   (AbsJump),
    .taken      (taken),
    .next_pc    (seq_pc),
    .bad_jump   (bad_jump)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    if (Start) begin
      state_d = RUN;
      pc_d    = PC_W'(START_ADDR);
      cnt_d   = '0;
      bad_d   = 1'b0;
    end else if (state_q == RUN && !Stall) begin
      cnt_d = sat_inc(cnt_q);
      // Halt retires but leaves PC pointing at the halt instruction.
      if (Halt) begin
        state_d = DONE;
      end else begin
        pc_d  = seq_pc;
        bad_d = bad_q | bad_jump;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
    end
  end

  assign PC        = pc_q;
  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == DONE);
  assign BadJump   = bad_q;
  assign InstCount = cnt_q;

endmodule
